// File: rtl/sobel_window_feeder.sv
// Builds a 3x3 pixel window from a raster stream and runs one start/ready handshake per interior pixel.
// Optional WAIT-state timeout: define SOBEL_FEEDER_TIMEOUT_EN.
module sobel_window_feeder #(
    parameter int IMG_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       i_pixel_valid,
    input  logic [7:0] i_pixel,
    input  logic       i_sof,
    output logic       o_pixel_ready,
    output logic       o_gradient_start,
    output logic [7:0] o_P0,
    output logic [7:0] o_P1,
    output logic [7:0] o_P2,
    output logic [7:0] o_P3,
    output logic [7:0] o_P4,
    output logic [7:0] o_P5,
    output logic [7:0] o_P6,
    output logic [7:0] o_P7,
    output logic [7:0] o_P8,
    input  logic       i_gradient_ready,
    input  logic [7:0] i_processed_sum,
    output logic       o_result_valid,
    output logic [7:0] o_result,
    output logic       o_timeout
);
    localparam int CW = $clog2(IMG_WIDTH);

    typedef enum logic [2:0] {IDLE, START, WAIT, OUTPUT, DRAIN} state_t;

    state_t        state;
    logic [CW-1:0] col;
    logic [1:0]    row;
    logic [7:0]    lb1 [IMG_WIDTH];
    logic [7:0]    lb2 [IMG_WIDTH];
    logic [7:0]    win [9];
    logic          accept;
    logic          interior;

    assign o_pixel_ready = (state == IDLE);
    assign accept        = i_pixel_valid && o_pixel_ready;
    // A start-of-frame pixel counts as (0,0), so it can never complete a window.
    assign interior      = !i_sof && (row == 2'd2) && (col >= CW'(2));

    assign o_P0 = win[0];
    assign o_P1 = win[1];
    assign o_P2 = win[2];
    assign o_P3 = win[3];
    assign o_P4 = win[4];
    assign o_P5 = win[5];
    assign o_P6 = win[6];
    assign o_P7 = win[7];
    assign o_P8 = win[8];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (i_sof) begin
                col <= CW'(1);
                row <= 2'd0;
            end else if (col == CW'(IMG_WIDTH - 1)) begin
                col <= '0;
                if (row != 2'd2)
                    row <= row + 2'd1;
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Line buffer taps are the pixels one and two rows above the incoming one.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < IMG_WIDTH; i++) begin
                lb1[i] <= '0;
                lb2[i] <= '0;
            end
            for (int i = 0; i < 9; i++)
                win[i] <= '0;
        end else if (accept) begin
            lb1[0] <= i_pixel;
            lb2[0] <= lb1[IMG_WIDTH-1];
            for (int i = 1; i < IMG_WIDTH; i++) begin
                lb1[i] <= lb1[i-1];
                lb2[i] <= lb2[i-1];
            end
            win[0] <= win[1];
            win[1] <= win[2];
            win[2] <= lb2[IMG_WIDTH-1];
            win[3] <= win[4];
            win[4] <= win[5];
            win[5] <= lb1[IMG_WIDTH-1];
            win[6] <= win[7];
            win[7] <= win[8];
            win[8] <= i_pixel;
        end
    end

`ifdef SOBEL_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
`else
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state            <= IDLE;
            o_gradient_start <= 1'b0;
            o_result_valid   <= 1'b0;
            o_result         <= '0;
`ifdef SOBEL_FEEDER_TIMEOUT_EN
            tmo_cnt          <= '0;
            o_timeout        <= 1'b0;
`endif
        end else begin
            o_gradient_start <= 1'b0;
            o_result_valid   <= 1'b0;
`ifdef SOBEL_FEEDER_TIMEOUT_EN
            o_timeout        <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept && interior) begin
                        state            <= START;
                        o_gradient_start <= 1'b1;
                    end
                end
                START: begin
                    state <= WAIT;
`ifdef SOBEL_FEEDER_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                WAIT: begin
                    if (i_gradient_ready) begin
                        o_result       <= i_processed_sum;
                        o_result_valid <= 1'b1;
                        state          <= OUTPUT;
                    end
`ifdef SOBEL_FEEDER_TIMEOUT_EN
                    else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        o_result       <= '0;
                        o_result_valid <= 1'b1;
                        o_timeout      <= 1'b1;
                        state          <= OUTPUT;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
`endif
                end
                OUTPUT: state <= DRAIN;
                // Swallow the detector's second ready cycle.
                DRAIN: begin
                    if (!i_gradient_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sobel_window_feeder.sv
// Randomized bench for sobel_window_feeder with an inline edge-detector responder and a history-based window model.
module tb_sobel_window_feeder;
    localparam int W   = 4;
    localparam int TMO = 64;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       i_pixel_valid, i_sof, i_gradient_ready;
    logic [7:0] i_pixel, i_processed_sum;
    logic       o_pixel_ready, o_gradient_start, o_result_valid, o_timeout;
    logic [7:0] o_P0, o_P1, o_P2, o_P3, o_P4, o_P5, o_P6, o_P7, o_P8, o_result;

    sobel_window_feeder #(.IMG_WIDTH(W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .n_rst(n_rst),
        .i_pixel_valid(i_pixel_valid), .i_pixel(i_pixel), .i_sof(i_sof),
        .o_pixel_ready(o_pixel_ready), .o_gradient_start(o_gradient_start),
        .o_P0(o_P0), .o_P1(o_P1), .o_P2(o_P2), .o_P3(o_P3), .o_P4(o_P4),
        .o_P5(o_P5), .o_P6(o_P6), .o_P7(o_P7), .o_P8(o_P8),
        .i_gradient_ready(i_gradient_ready), .i_processed_sum(i_processed_sum),
        .o_result_valid(o_result_valid), .o_result(o_result), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] hist[$];
    int         npix = 0;
    logic [7:0] last_res = 8'h00;
    int         dut_starts = 0;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] dut_win();
        return {o_P0, o_P1, o_P2, o_P3, o_P4, o_P5, o_P6, o_P7, o_P8};
    endfunction

    // back = 0 is the newest accepted pixel; anything older than history is a reset zero.
    function automatic logic [7:0] past(input int back);
        if (back < hist.size())
            return hist[hist.size() - 1 - back];
        return 8'h00;
    endfunction

    function automatic logic [71:0] exp_window();
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int j = 0; j < 3; j++)
                w[8*(8 - (3*r + j)) +: 8] = past((2 - r) * W + (2 - j));
        return w;
    endfunction

    task automatic model_reset();
        hist.delete();
        npix     = 0;
        last_res = 8'h00;
    endtask

    // Responder: answer dly cycles after the start cycle, hold ready for 2 cycles.
    task automatic run_txn(input int dly, input logic [7:0] val, input logic [71:0] win);
        int busy;
        busy = 0;
        check("start_pulse", 72'(o_gradient_start), 72'd1);
        check("start_window", dut_win(), win);
        for (int i = 0; i < dly; i++) begin
            i_pixel_valid = 1'b1;
            i_sof         = 1'b1;
            i_pixel       = 8'($urandom);
            @(posedge clk); #1;
            busy += int'(o_result_valid) + int'(o_gradient_start) + int'(o_pixel_ready);
        end
        i_pixel_valid = 1'b0;
        i_sof         = 1'b0;
        check("wait_quiet", 72'(busy), 72'd0);
        check("window_hold", dut_win(), win);
        i_gradient_ready = 1'b1;
        i_processed_sum  = val;
        @(posedge clk); #1;
        check("result_valid", 72'(o_result_valid), 72'd1);
        check("result_value", 72'(o_result), 72'(val));
        @(posedge clk); #1;
        i_gradient_ready = 1'b0;
        i_processed_sum  = 8'($urandom);
        check("drain_no_second", 72'({o_result_valid, o_pixel_ready}), 72'd0);
        check("drain_window", dut_win(), win);
        @(posedge clk); #1;
        check("ready_after_drain", 72'(o_pixel_ready), 72'd1);
        last_res = val;
    endtask

    // dly < 0 leaves the DUT sitting in START for the caller to handle.
    task automatic push(input logic [7:0] p, input logic s, input int dly, input logic [7:0] val);
        int   row, col;
        logic intr;
        check("ready_idle", 72'(o_pixel_ready), 72'd1);
        check("result_hold", 72'(o_result), 72'(last_res));
        row  = (npix / W > 2) ? 2 : npix / W;
        col  = npix % W;
        intr = !s && row == 2 && col >= 2;
        i_pixel_valid = 1'b1;
        i_pixel       = p;
        i_sof         = s;
        @(posedge clk); #1;
        i_pixel_valid = 1'b0;
        i_sof         = 1'b0;
        dut_starts += int'(o_gradient_start);
        hist.push_back(p);
        if (hist.size() > 3 * W)
            void'(hist.pop_front());
        npix = s ? 1 : npix + 1;
        if (!intr)
            check("no_start", 72'(o_gradient_start), 72'd0);
        else if (dly >= 0)
            run_txn(dly, val, exp_window());
        else
            check("start_window", dut_win(), exp_window());
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, 72'({o_pixel_ready, o_gradient_start, o_result_valid, o_timeout, o_result}),
              72'({1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
        check({tag, "_window"}, dut_win(), 72'd0);
    endtask

    initial begin
        int s0, rv, lat;
        logic [7:0] frame [12];
        n_rst = 1'b0;
        i_pixel_valid = 1'b0; i_pixel = 8'h00; i_sof = 1'b0;
        i_gradient_ready = 1'b0; i_processed_sum = 8'h00;
        #1;
        check_reset_outputs("reset_state");
        @(posedge clk); @(posedge clk); #1;
        n_rst = 1'b1;
        @(posedge clk); #1;

        // First window: rows [0,0,255,255] x3, then row 3 for the wrap case.
        for (int i = 0; i < 12; i++)
            frame[i] = (i % W >= 2) ? 8'hFF : 8'h00;
        for (int i = 0; i < 12; i++) begin
            push(frame[i], i == 0, i == 10 ? -1 : $urandom_range(1, 20), 8'($urandom));
            if (i == 10) begin
                check("first_window", dut_win(),
                      {8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255});
                run_txn(20, 8'h5A, exp_window());
            end
        end
        s0 = dut_starts;
        push(8'h11, 1'b0, 5, 8'h00);
        push(8'h22, 1'b0, 5, 8'h00);
        check("wrap_no_start", 72'(dut_starts - s0), 72'd0);
        push(8'h33, 1'b0, 7, 8'hC3);
        check("wrap_start", 72'(dut_starts - s0), 72'd1);

        // Mid-frame restart at row 2 col 1.
        push(8'($urandom), 1'b1, 3, 8'h00);
        for (int i = 0; i < 8; i++) push(8'($urandom), 1'b0, 3, 8'h00);
        s0 = dut_starts;
        push(8'($urandom), 1'b1, 3, 8'h00);
        for (int i = 0; i < 9; i++) push(8'($urandom), 1'b0, 3, 8'h00);
        check("restart_quiet", 72'(dut_starts - s0), 72'd0);
        push(8'($urandom), 1'b0, 4, 8'h77);
        check("restart_start", 72'(dut_starts - s0), 72'd1);

        // Random stream with idle gaps carrying stray i_sof.
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                i_sof = 1'($urandom);
                @(posedge clk); #1;
                i_sof = 1'b0;
                check("gap_no_start", 72'(o_gradient_start), 72'd0);
            end else begin
                push(8'($urandom), $urandom_range(0, 29) == 0, $urandom_range(1, 20), 8'($urandom));
            end
        end

        // Detector that never answers.
        push(8'($urandom), 1'b1, 3, 8'h00);
        for (int i = 0; i < 10; i++) push(8'($urandom), 1'b0, i == 9 ? -1 : 3, 8'h00);
        lat = 0;
        rv  = 0;
`ifdef SOBEL_FEEDER_TIMEOUT_EN
        for (int i = 0; i < 200 && !o_result_valid; i++) begin
            @(posedge clk); #1;
            lat++;
        end
        check("tmo_valid", 72'(o_result_valid), 72'd1);
        check("tmo_result", 72'(o_result), 72'd0);
        check("tmo_flag", 72'(o_timeout), 72'd1);
        check("tmo_latency", 72'(lat >= TMO && lat <= TMO + 1), 72'd1);
        last_res = 8'h00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("tmo_ready_back", 72'(o_pixel_ready), 72'd1);
        push(8'($urandom), 1'b0, -1, 8'h00);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
`else
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            rv += int'(o_result_valid) + int'(o_pixel_ready) + int'(o_timeout);
        end
        check("wait_unbounded", 72'(rv), 72'd0);
`endif

        // Reset in the middle of WAIT aborts the transaction.
        n_rst = 1'b0;
        #1;
        check_reset_outputs("reset_mid_wait");
        @(posedge clk); #1;
        n_rst = 1'b1;
        model_reset();
        i_gradient_ready = 1'b1;
        i_processed_sum  = 8'hAA;
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_gradient_ready = 1'b0;
        rv = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            rv += int'(o_result_valid);
        end
        check("no_result_after_reset", 72'(rv), 72'd0);
        check_reset_outputs("post_reset_idle");

        // Fresh frame after reset still works.
        for (int i = 0; i < 12; i++)
            push(8'($urandom), i == 0, $urandom_range(1, 20), 8'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sobel_window_feeder.md
# sobel_window_feeder

Initiator side of the Sobel gradient handshake: accepts a raster-order 8-bit pixel stream, builds the 3x3 neighbourhood with two line buffers, and drives the window and `i_gradient_start` into `edge_detection`. It captures `o_processed_sum` on the first `o_gradient_ready` cycle and re-emits it as one result beat per interior pixel. It sits between the pixel source and the edge-detection datapath.

## Interface
- `IMG_WIDTH`, 16: pixels per image row, ≥ 3.
- `TIMEOUT_CYCLES`, 64: WAIT-state bound, used only when the timeout feature is compiled in.

- `clk`  in  1  clock; all state changes on the rising edge.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `i_pixel_valid`  in  1  pixel present on `i_pixel`.
- `i_pixel`  in  8  unsigned pixel.
- `i_sof`  in  1  start of frame, qualified by pixel acceptance.
- `o_pixel_ready`  out  1  feeder can accept a pixel.
- `o_gradient_start`  out  1  one-cycle start pulse to the edge detector.
- `o_P0`..`o_P8`  out  8 each  window: P0 P1 P2 top row, P3 P4 P5 middle row, P6 P7 P8 bottom row; P8 is the newest pixel.
- `i_gradient_ready`  in  1  detector result valid (high 2 cycles per result).
- `i_processed_sum`  in  8  detector result.
- `o_result_valid`  out  1  one-cycle result strobe.
- `o_result`  out  8  captured result.
- `o_timeout`  out  1  one-cycle pulse when a result is forced by timeout.

## Operation
- **Accept condition:** a pixel is accepted when `i_pixel_valid && o_pixel_ready`.
- **Ready:** `o_pixel_ready` = (state == IDLE). It is combinational.
- **Window shift on each accept:**
  - top row: P0←P1, P1←P2, P2←LB2 tap
  - middle row: P3←P4, P4←P5, P5←LB1 tap
  - bottom row: P6←P7, P7←P8, P8←`i_pixel`
- **Line buffers:** LB1 and LB2 are shift registers of depth `IMG_WIDTH`. On each accept, LB1 pushes `i_pixel` and LB2 pushes the LB1 tap.
- **Counters:**
  - col counts 0..IMG_WIDTH-1 and wraps to 0; on wrap, row increments and saturates at 2.
  - An accepted pixel with `i_sof`=1 is treated as col 0, row 0. The line buffers are not cleared.
- **Interior pixel:** an accepted pixel at row ≥ 2 and col ≥ 2 (counter values *before* the update) completes a window.
- **FSM:**
  - IDLE: an interior accept → START. Any other accept stays in IDLE.
  - START: `o_gradient_start`=1 → WAIT.
  - WAIT: `i_gradient_ready`=1 → capture `i_processed_sum` into `o_result` → OUTPUT.
  - OUTPUT: `o_result_valid`=1 → DRAIN.
  - DRAIN: stays until `i_gradient_ready`=0 → IDLE. This guarantees the detector's second ready cycle never produces a second result.
- **Window stability:** P0..P8 are held constant from START until DRAIN exits, because the detector samples the window across many cycles.
- **Reset:** all outputs are 0 except `o_pixel_ready`=1. State is IDLE, and counters, window and line buffers are 0. Reset mid-transaction aborts it, and no result is emitted.

## Timing
- Interior pixel accepted at edge k: `o_gradient_start` is high during cycle k+1 only.
- Ready first seen high at edge m: `o_result_valid` is high during cycle m+1, and `o_result` is stable from m+1 until the next capture.
- Earliest `o_pixel_ready` after a result: the cycle after `i_gradient_ready` is sampled low in DRAIN.
- Non-interior pixels are accepted one per cycle with no gaps.
- `i_sof` together with a non-accepted beat has no effect.

## Configuration
- `SOBEL_FEEDER_TIMEOUT_EN` defined:
  - A counter starts at WAIT entry.
  - If `i_gradient_ready` is not seen within `TIMEOUT_CYCLES` cycles, the FSM captures `o_result`=8'h00, pulses `o_timeout` together with `o_result_valid` in OUTPUT, and goes to DRAIN.
- Not defined:
  - WAIT is unbounded.
  - `o_timeout` is tied to 0.

## Test plan
All scenarios use `IMG_WIDTH`=4 and a responder stub modelling `edge_detection` timing (ready after 20 cycles, held 2 cycles).
- **Reset:** assert `n_rst`=0 mid-WAIT → all outputs 0, `o_pixel_ready`=1; after release, no `o_result_valid` appears.
- **First window:** stream rows [0,0,255,255]×3 with `i_sof` on the first pixel → the 11th pixel (row 2, col 2) gives `o_gradient_start` one cycle later with P0..P8 = {0,0,255, 0,0,255, 0,0,255}; `o_pixel_ready`=0 until DRAIN exits.
- **Single result:** stub returns 8'h5A for 2 cycles → exactly one `o_result_valid` with `o_result`=8'h5A; `o_pixel_ready` rises the cycle after ready drops.
- **Row wrap:** continue to row 3 col 0 and col 1 → no start; row 3 col 2 → start with the window from rows 1-3.
- **Mid-frame restart:** `i_sof` at row 2 col 1 → no start until 10 more pixels have been accepted.
- **Timeout (macro on):** stub never responds → `o_result_valid`=1, `o_result`=8'h00, `o_timeout`=1 at 64 cycles after START. **Macro off:** still in WAIT after 1000 cycles.
